// File: rtl/cpu_stage_ctrl.sv
// Purpose  : multicycle stage sequencer for the CPU core. Walks each instruction
//            through IF/ID/EX/MEM/WB, skipping stages by opcode class.
// Latency  : zero-wait memory, IFETCH entry to retire pulse: ALU 4, BR 3, LD 5, ST 4.
// Backpressure: stall freezes every register except the retire pulse. Memory
//            handshakes are req/ack; an ack that arrives while stalled is dropped.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   stall                global freeze (ignored in TRAP)
//   imem_req/ack/rdata   instruction fetch handshake, rdata sampled with ack
//   dmem_req/we/ack      data access handshake, we=1 for stores
//   instr                latched instruction word
//   stage                one-hot {WB,MEM,EX,ID,IF}, 0 in IDLE/TRAP
//   reg_we               register-file write strobe (WRITEBACK)
//   retire, retire_count completion pulse and saturating completion counter
//   trap, trap_cause     trap flag and cause (01 illegal op, 10 mem timeout)
//   trap_clr             leave TRAP and resume fetching
module cpu_stage_ctrl #(
   parameter int INSTR_WIDTH = 32,
   parameter int OP_WIDTH    = 6,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   output logic                   imem_req,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   dmem_req,
   output logic                   dmem_we,
   input  logic                   dmem_ack,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [4:0]             stage,
   output logic                   reg_we,
   output logic                   retire,
   output logic [CNT_WIDTH-1:0]   retire_count,
   output logic                   trap,
   output logic [1:0]             trap_cause,
   input  logic                   trap_clr
);

   // The timeout counter only ever needs to hold 0 .. MEM_TIMEOUT-1.
   localparam int TO_WIDTH = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_WIDTH-1:0] TO_LAST =
      TO_WIDTH'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Opcode values are zero-extended into the OP_WIDTH field.
   localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(6'h00);
   localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(6'h01);
   localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(6'h02);
   localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(6'h03);
   localparam logic [OP_WIDTH-1:0] OP_BEQ = OP_WIDTH'(6'h04);
   localparam logic [OP_WIDTH-1:0] OP_J   = OP_WIDTH'(6'h05);
   localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(6'h23);
   localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(6'h2B);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_IFETCH    = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_TRAP      = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_ILL = 3'd0,
      CLS_ALU = 3'd1,
      CLS_BR  = 3'd2,
      CLS_LD  = 3'd3,
      CLS_ST  = 3'd4
   } op_cls_t;

   state_t                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [1:0]             trap_cause_q, trap_cause_d;
   logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_d;
   logic                   retire_q, retire_d;
   logic [CNT_WIDTH-1:0]   retire_count_q, retire_count_d;

   logic [OP_WIDTH-1:0]    opcode;
   op_cls_t                op_cls;
   logic                   complete;

   // ------------------------------------------------------------------
   // Opcode classification of the latched instruction. Used in DECODE to
   // pick the route, and again in EXECUTE/MEMORY so no class register is
   // needed (instr is frozen for the whole instruction).
   // ------------------------------------------------------------------
   assign opcode = instr_q[INSTR_WIDTH-1 -: OP_WIDTH];

   always_comb begin
      op_cls = CLS_ILL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR: op_cls = CLS_ALU;
         OP_BEQ, OP_J:                  op_cls = CLS_BR;
         OP_LW:                         op_cls = CLS_LD;
         OP_SW:                         op_cls = CLS_ST;
         default:                       op_cls = CLS_ILL;
      endcase
   end

   // ------------------------------------------------------------------
   // Next-state logic. Every transition except leaving TRAP is gated by
   // !stall, which also drops any ack seen during a stalled cycle.
   // ------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      instr_d        = instr_q;
      trap_cause_d   = trap_cause_q;
      to_cnt_d       = to_cnt_q;
      complete       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!stall) begin
               state_d = S_IFETCH;
            end
         end

         S_IFETCH: begin
            if (!stall && imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            if (!stall) begin
               if (op_cls == CLS_ILL) begin
                  state_d      = S_TRAP;
                  trap_cause_d = 2'b01;
               end else begin
                  state_d = S_EXECUTE;
               end
            end
         end

         S_EXECUTE: begin
            if (!stall) begin
               case (op_cls)
                  CLS_ALU:         state_d = S_WRITEBACK;
                  CLS_LD, CLS_ST:  state_d = S_MEMORY;
                  default: begin
                     // Branches finish here; illegal ops never reach EXECUTE.
                     state_d  = S_IFETCH;
                     complete = 1'b1;
                  end
               endcase
            end
         end

         S_MEMORY: begin
            if (!stall) begin
               if (dmem_ack) begin
                  // Ack takes priority over a timeout in the same cycle.
                  to_cnt_d = '0;
                  if (op_cls == CLS_ST) begin
                     state_d  = S_IFETCH;
                     complete = 1'b1;
                  end else begin
                     state_d = S_WRITEBACK;
                  end
               end else if ((MEM_TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
                  // This is the MEM_TIMEOUT-th cycle without an ack.
                  to_cnt_d     = '0;
                  state_d      = S_TRAP;
                  trap_cause_d = 2'b10;
               end else begin
                  to_cnt_d = to_cnt_q + TO_WIDTH'(1);
               end
            end
         end

         S_WRITEBACK: begin
            if (!stall) begin
               state_d  = S_IFETCH;
               complete = 1'b1;
            end
         end

         S_TRAP: begin
            // Stall does not hold the core in TRAP.
            if (trap_clr) begin
               state_d      = S_IFETCH;
               trap_cause_d = 2'b00;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Retire is the registered image of the completing transition, so it
      // lasts exactly one cycle even if stall rises right after.
      retire_d = complete;
      if (complete && (retire_count_q != CNT_MAX)) begin
         retire_count_d = retire_count_q + CNT_WIDTH'(1);
      end else begin
         retire_count_d = retire_count_q;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         instr_q        <= '0;
         trap_cause_q   <= 2'b00;
         to_cnt_q       <= '0;
         retire_q       <= 1'b0;
         retire_count_q <= '0;
      end else begin
         state_q        <= state_d;
         instr_q        <= instr_d;
         trap_cause_q   <= trap_cause_d;
         to_cnt_q       <= to_cnt_d;
         retire_q       <= retire_d;
         retire_count_q <= retire_count_d;
      end
   end

   // ------------------------------------------------------------------
   // Moore outputs, decoded from registers only. Because the state is
   // frozen during a stall, the req strobes naturally hold their value.
   // ------------------------------------------------------------------
   always_comb begin
      stage    = 5'b00000;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
      trap     = 1'b0;

      unique case (state_q)
         S_IFETCH:    begin stage = 5'b00001; imem_req = 1'b1; end
         S_DECODE:    begin stage = 5'b00010; end
         S_EXECUTE:   begin stage = 5'b00100; end
         S_MEMORY: begin
            stage    = 5'b01000;
            dmem_req = 1'b1;
            dmem_we  = (op_cls == CLS_ST);
         end
         S_WRITEBACK: begin stage = 5'b10000; reg_we = 1'b1; end
         S_TRAP:      begin trap = 1'b1; end
         default:     begin stage = 5'b00000; end
      endcase
   end

   assign instr        = instr_q;
   assign retire       = retire_q;
   assign retire_count = retire_count_q;
   assign trap_cause   = trap_cause_q;

endmodule

// File: doc/cpu_stage_ctrl.md
Name: cpu_stage_ctrl

Overview:
- Parametrised multicycle control FSM for the CPU core. Sequences each instruction through IFetch, Decode, Execute, Memory and Writeback.
- Skips stages by opcode class and handshakes with instruction and data memory via req/ack.
- Supports a global stall, a memory timeout, and a trap state for illegal ops and timeouts.
- Sits between the memory interfaces and the datapath; drives stage strobes, register write enable and a retired-instruction counter.

Parameters:
INSTR_WIDTH, 32, instruction word width; opcode = instr[INSTR_WIDTH-1 -: OP_WIDTH]
OP_WIDTH, 6, opcode field width (>= 6)
MEM_TIMEOUT, 16, max wait cycles for dmem_ack in Memory; 0 disables timeout
CNT_WIDTH, 16, width of retire_count (saturating)

Ports:
clk  in  1  single clock, all state changes on posedge
rst_n  in  1  asynchronous, active-low reset
stall  in  1  freezes FSM, counters and latched instr while high
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  INSTR_WIDTH  fetched instruction
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
dmem_ack  in  1  data access complete
instr  out  INSTR_WIDTH  latched current instruction
stage  out  5  one-hot {WB,MEM,EX,ID,IF}; 0 in IDLE/TRAP
reg_we  out  1  register-file write strobe
retire  out  1  one-cycle pulse per completed instruction
retire_count  out  CNT_WIDTH  retired instructions, saturates at all-ones
trap  out  1  high while in TRAP
trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none
trap_clr  in  1  leave TRAP

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; instr, retire_count, trap_cause, timeout counter = 0.
  - All outputs 0 while rst_n low, including imem_req and dmem_req.
  - Reset mid-transaction abandons it; no retire.
- States: IDLE, IFETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- All outputs are Moore (decoded from state/registers) except as noted.
- IDLE: one cycle, then IFETCH.
- IFETCH:
  - imem_req=1.
  - At posedge with imem_ack=1 and stall=0: latch instr<=imem_rdata, go DECODE.
  - Otherwise hold; imem_req stays high.
- DECODE: one cycle. Classify opcode:
  - ALU = ADD 0x00, SUB 0x01, AND 0x02, OR 0x03
  - BR = BEQ 0x04, J 0x05
  - LD = LW 0x23
  - ST = SW 0x2B
  - Any other value: go TRAP, trap_cause<=01.
  - Valid opcodes go EXECUTE.
- EXECUTE: one cycle. Next state: ALU->WRITEBACK, LD/ST->MEMORY, BR->IFETCH (instruction complete).
- MEMORY:
  - dmem_req=1; dmem_we=1 for ST, 0 for LD.
  - On dmem_ack=1 (stall=0): LD->WRITEBACK, ST->IFETCH (complete). Timeout counter cleared.
  - Each cycle without ack, counter increments.
  - If MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT-1 with no ack: go TRAP, trap_cause<=10.
  - Ack and timeout in the same cycle: ack wins.
- WRITEBACK: reg_we=1 for exactly this cycle; then IFETCH (complete).
- Completion:
  - retire is a registered pulse, high for the one cycle following the completing transition.
  - retire_count increments on that same edge; saturates at 2^CNT_WIDTH-1 (no wrap).
- Latency with zero-wait memory, from IFETCH entry to retire pulse:
  - ALU 4 cycles
  - BR 3 cycles
  - LD 5 cycles
  - ST 4 cycles
- TRAP:
  - trap=1; no req asserted; ignores stall.
  - trap_clr=1 at posedge: go IFETCH, trap_cause<=00. Trapping instruction does not retire.
- stall=1:
  - No state transition, no latch, no counter update, timeout counter frozen.
  - Req outputs keep their current value.
  - Any ack arriving while stalled is ignored; memory must re-ack.
  - reg_we stays high while stalled in WRITEBACK; the write is idempotent.
- Unused opcode bits above OP_WIDTH do not exist; opcode compare is zero-extended to OP_WIDTH.

Test Plan:
1. Reset release, imem_ack=1 with ADD (0x00), zero-wait -> IDLE 1 cycle; stage IF,ID,EX,WB one-hot 00001,00010,00100,10000; reg_we in the WB cycle only; retire 1 cycle later; retire_count=1.
2. LW (0x23), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; then WB with reg_we=1; retire; SW (0x2B) instead -> dmem_we=1, no WB, no reg_we, retire after ack.
3. Opcode 0x3F -> after DECODE, trap=1, trap_cause=01, stage=0, no retire; trap_clr pulse -> IFETCH, trap_cause=00, imem_req=1.
4. MEM_TIMEOUT=4, LW with dmem_ack never asserted -> exactly 4 MEMORY cycles then trap_cause=10; repeat with ack on the 4th cycle -> no trap, WB reached.
5. stall high 3 cycles during EXECUTE of ADD, plus an imem_ack pulse while stalled in IFETCH -> state and instr unchanged while stalled; instruction retires exactly 3 cycles late; the stalled ack is ignored.
6. CNT_WIDTH=2, run 5 BEQ (0x04) instructions -> retire pulses 5 times, retire_count 1,2,3,3,3; assert rst_n low mid-MEMORY -> all outputs 0 immediately, retire_count=0.
